// File: rtl/mem_load_unit_if.sv
// rtl/mem_load_unit_if.sv - request, memory-read and response signals of the load unit
interface mem_load_unit_if #(
    parameter int ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [2:0]        req_type;
    logic [4:0]        req_rd;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic              resp_misalign;

    modport master (
        input  req_valid, req_addr, req_type, req_rd, mem_rd_data, resp_ready,
        output req_ready, mem_rd_en, mem_rd_addr, resp_valid, resp_data, resp_rd, resp_misalign
    );

    modport slave (
        output req_valid, req_addr, req_type, req_rd, mem_rd_data, resp_ready,
        input  req_ready, mem_rd_en, mem_rd_addr, resp_valid, resp_data, resp_rd, resp_misalign
    );
endinterface

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MEM-stage load unit: word read, lane select, sign/zero extend
// Optional macro LOAD_EXC_EN: misaligned LH/LHU/LW return a misalign flag instead of reading.
module mem_load_unit #(
    parameter int ADDR_W      = 7,
    parameter int MEM_LATENCY = 1
) (
    input logic            clk,
    input logic            rst_n,
    mem_load_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} loadStateT;

    loadStateT   state, nextState;
    logic [1:0]  cnt, cntNext;
    logic [1:0]  addrLo;
    logic [2:0]  typeReg;
    logic [4:0]  rdReg;
    logic [31:0] respData;
    logic        respMisalign;
    logic        accept;
    logic        misalignReq;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^bus.req_addr[31:ADDR_W+2];

    // Gating with rst_n keeps the strobe low while reset is held, whatever req_valid does.
    assign accept = rst_n && (state == IDLE) && bus.req_valid;

`ifdef LOAD_EXC_EN
    logic isHalfReq, isWordReq;
    assign isHalfReq   = (bus.req_type == 3'b001) || (bus.req_type == 3'b101);
    assign isWordReq   = !((bus.req_type == 3'b000) || (bus.req_type == 3'b100) || isHalfReq);
    assign misalignReq = (isHalfReq && bus.req_addr[0]) || (isWordReq && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalignReq = 1'b0;
`endif

    function automatic logic [31:0] loadExtend(input logic [2:0] ty, input logic [1:0] lo,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        // Halfword lane ignores lo[0]; word path ignores lo entirely, which force-aligns.
        h = lo[1] ? word[31:16] : word[15:0];
        case (ty)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            addrLo   <= 2'd0;
            typeReg  <= 3'd0;
            rdReg    <= 5'd0;
            respData <= 32'd0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
            if (accept) begin
                addrLo   <= bus.req_addr[1:0];
                typeReg  <= bus.req_type;
                rdReg    <= bus.req_rd;
                respData <= 32'd0;
            end
            if (state == WAIT && cnt == 2'd0) begin
                respData <= loadExtend(typeReg, addrLo, bus.mem_rd_data);
            end
        end
    end

`ifdef LOAD_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respMisalign <= 1'b0;
        end else if (accept) begin
            respMisalign <= misalignReq;
        end
    end
`else
    assign respMisalign = 1'b0;
`endif

    always_comb begin
        nextState = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalignReq) begin
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                        cntNext   = 2'(MEM_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    nextState = RESP;
                end else begin
                    cntNext = cnt - 2'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_rd_en     = accept && !misalignReq;
    assign bus.mem_rd_addr   = bus.mem_rd_en ? bus.req_addr[ADDR_W+1:2] : '0;
    assign bus.resp_valid    = (state == RESP);
    assign bus.resp_data     = respData;
    assign bus.resp_rd       = rdReg;
    assign bus.resp_misalign = respMisalign;
endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Load-side counterpart of the data memory write path, in the MEM stage.
- Accepts one load request at a time and issues a word read to a synchronous-read data memory with fixed latency.
- Selects the byte or halfword lane, then sign- or zero-extends it.
- Returns the 32-bit result with its destination-register tag over a valid/ready handshake to the writeback side.

Parameters:
- ADDR_W, 7, word-address width; memory depth is 2^ADDR_W words, and byte address bits [ADDR_W+1:2] select the word.
- MEM_LATENCY, 1, cycles from mem_rd_en high to mem_rd_data valid; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_addr  input  32  byte address.
- req_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes behave as LW.
- req_rd  input  5  destination register tag.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rd_addr  output  ADDR_W  word address.
- mem_rd_data  input  32  read data, valid exactly MEM_LATENCY cycles after the strobe.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  extended load result.
- resp_rd  output  5  tag copied from the request.
- resp_misalign  output  1  misaligned-access flag; only driven when LOAD_EXC_EN is defined.

Behaviour:
- Reset: asynchronous, applied immediately, regardless of state. All outputs go to 0 except req_ready, which is 1. State goes to IDLE, the latency counter to 0, and any in-flight read is discarded. Memory data arriving after reset deasserts is ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch addr[1:0], type and rd.
  - Drive mem_rd_en=1 and mem_rd_addr=req_addr[ADDR_W+1:2] combinationally in the same cycle.
  - Load the latency counter with MEM_LATENCY-1, then go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When it is 0, capture mem_rd_data, perform lane select and extension, register the result into resp_data, and go to RESP.
  - Minimum accept-to-resp_valid latency is MEM_LATENCY+1 cycles.
- Lane select (little-endian, matching the store lanes):
  - Byte: addr[1:0]=00 uses [7:0], 01 uses [15:8], 10 uses [23:16], 11 uses [31:24].
  - Halfword: addr[1]=0 uses [15:0], 1 uses [31:16].
  - Word: the full word.
- Extension: LB and LH replicate the selected lane's MSB into the upper bits; LBU and LHU fill with zeros.
- RESP:
  - resp_valid=1. resp_data and resp_rd hold stable until resp_ready is high.
  - On the handshake, resp_valid drops the next cycle and the FSM returns to IDLE.
  - No back-to-back overlap: req_ready stays 0 during RESP, even in the handshake cycle.
  - resp_valid never asserts without a preceding accepted request.
- mem_rd_en is high for exactly one cycle per accepted request, and never while in WAIT or RESP.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo memory size).

Optional Feature:
- Macro: LOAD_EXC_EN.
- Defined:
  - LH or LHU with addr[0]=1, or LW with addr[1:0]!=00, is misaligned.
  - A misaligned request issues no memory read. The FSM goes directly IDLE->RESP with resp_data=0 and resp_misalign=1; resp_rd still carries the tag.
  - resp_misalign is 0 for all aligned responses.
- Undefined:
  - resp_misalign is tied to 0.
  - Misaligned addresses are forced aligned: LH/LHU ignore addr[0], and LW ignores addr[1:0].
  - These accesses are read and returned normally.

Test Plan:
- LB, addr 0x0000_0003, memory word 0x80AB_CD12 -> resp_data 0xFFFF_FF80. The same with LBU -> 0x0000_0080.
- LH, addr 0x0000_0006, word 0x9234_5678 -> 0xFFFF_9234. LHU, addr 0x0000_0004, same word -> 0x0000_5678.
- MEM_LATENCY=2, LW, addr 0x0000_0010, rd=5 -> mem_rd_en pulses once with mem_rd_addr 4. resp_valid rises exactly 3 cycles after accept, with data equal to the word and resp_rd=5.
- Backpressure: resp_ready held 0 for 4 cycles while req_valid stays high -> resp_data stable, req_ready=0, no second mem_rd_en. Accepted one cycle after the handshake.
- With LOAD_EXC_EN, LW at 0x0000_0002 -> no mem_rd_en, resp_valid the next cycle, data 0, misalign 1. Without the macro -> reads word 0 and misalign 0.
- rst_n pulsed low during WAIT -> outputs are 0 and req_ready is 1 immediately. The late mem_rd_data is ignored, and no resp_valid appears.
